// File: rtl/dump_stage.sv
// dump_stage: final SHAKE pipeline stage. Captures squeezed rate blocks from
// the permute stage and serialises them into W-bit words on a valid/ready
// stream, truncated to the requested output length with the final word flagged.
module dump_stage #(
    parameter int RATE     = 1344,
    parameter int RATE_256 = 1088,
    parameter int W        = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RATE-1:0] rate_input,
    input  logic            output_buffer_we,
    output logic            output_buffer_ready,
    input  logic [31:0]     output_size,
    input  logic [1:0]      operation_mode,
    input  logic            copy_control_regs_en,
    output logic [W-1:0]    dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            dout_last
);

    localparam int          SW        = $clog2(W);
    localparam logic [31:0] W32       = 32'(W);
    localparam logic [4:0]  LAST_128  = 5'(RATE / W - 1);
    localparam logic [4:0]  LAST_256  = 5'(RATE_256 / W - 1);
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {EMPTY, DRAIN} state_t;

    state_t          state;
    logic [RATE-1:0] buffer;
    logic [4:0]      word_idx;
    logic [31:0]     remaining;
    logic [1:0]      mode;
    logic [31:0]     pend_size;
    logic [1:0]      pend_mode;
    logic            pend_valid;

    logic            under_w;
    logic            last_word;
    logic [31:0]     step;
    logic [W-1:0]    word_mask;
    logic [4:0]      block_end_idx;
    logic            fire;
    logic            leave;
    logic [31:0]     eff_remaining;
    logic            load;

    // Word masking, handshake and block-boundary decode from the active registers
    always_comb begin
        under_w       = remaining < W32;
        last_word     = remaining <= W32;
        step          = under_w ? remaining : W32;
        word_mask     = under_w ? ((ONE << remaining[SW-1:0]) - ONE) : '1;
        block_end_idx = (mode == 2'b00) ? LAST_128 : LAST_256;
        fire          = dout_valid && dout_ready;
        leave         = fire && (last_word || word_idx == block_end_idx);
        // A copy strobe in EMPTY takes effect before the accept decision
        eff_remaining = copy_control_regs_en ? output_size : remaining;
        load          = (state == EMPTY) && output_buffer_we && (eff_remaining != '0);
    end

    assign dout      = (state == DRAIN) ? (buffer[W-1:0] & word_mask) : '0;
    assign dout_last = (state == DRAIN) && last_word;

    // Control FSM: active/pending control registers and registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= EMPTY;
            remaining           <= '0;
            mode                <= '0;
            pend_size           <= '0;
            pend_mode           <= '0;
            pend_valid          <= 1'b0;
            word_idx            <= '0;
            dout_valid          <= 1'b0;
            output_buffer_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (copy_control_regs_en) begin
                        remaining <= output_size;
                        mode      <= operation_mode;
                    end
                    if (load) begin
                        state               <= DRAIN;
                        word_idx            <= '0;
                        dout_valid          <= 1'b1;
                        output_buffer_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (copy_control_regs_en) begin
                        pend_size  <= output_size;
                        pend_mode  <= operation_mode;
                        pend_valid <= 1'b1;
                    end
                    if (fire) begin
                        word_idx  <= word_idx + 5'd1;
                        remaining <= remaining - step;
                    end
                    if (leave) begin
                        state               <= EMPTY;
                        dout_valid          <= 1'b0;
                        output_buffer_ready <= 1'b1;
                        // Pending controls land on the exit edge so a block
                        // offered on the first EMPTY cycle sees the new length;
                        // a copy on that very edge is the most recent request.
                        if (copy_control_regs_en) begin
                            remaining  <= output_size;
                            mode       <= operation_mode;
                            pend_valid <= 1'b0;
                        end else if (pend_valid) begin
                            remaining  <= pend_size;
                            mode       <= pend_mode;
                            pend_valid <= 1'b0;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Block buffer: load on accept, shift one word out per handshake
    always_ff @(posedge clk) begin
        if (load) begin
            buffer <= rate_input;
        end else if (fire) begin
            buffer <= buffer >> W;
        end
    end

endmodule

// File: tb/tb_dump_stage.sv
// tb_dump_stage: directed self-checking bench for dump_stage.
module tb_dump_stage;

    logic           clk = 1'b0;
    logic           rst;
    logic [1343:0]  rate_input;
    logic           output_buffer_we;
    logic           output_buffer_ready;
    logic [31:0]    output_size;
    logic [1:0]     operation_mode;
    logic           copy_control_regs_en;
    logic [63:0]    dout;
    logic           dout_valid;
    logic           dout_ready;
    logic           dout_last;

    int tests = 0;
    int fails = 0;
    int violations = 0;

    dump_stage #(.RATE(1344), .RATE_256(1088), .W(64)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rate_input           (rate_input),
        .output_buffer_we     (output_buffer_we),
        .output_buffer_ready  (output_buffer_ready),
        .output_size          (output_size),
        .operation_mode       (operation_mode),
        .copy_control_regs_en (copy_control_regs_en),
        .dout                 (dout),
        .dout_valid           (dout_valid),
        .dout_ready           (dout_ready),
        .dout_last            (dout_last)
    );

    always #5 clk = ~clk;

    // Offering a block while the stage is busy is a protocol violation
    always @(posedge clk) begin
        if (!rst && output_buffer_we && !output_buffer_ready) violations++;
    end

    function automatic logic [63:0] kword(input int k, input logic [63:0] x);
        return (64'h1111_1111_1111_1111 * 64'(k)) ^ x;
    endfunction

    task automatic make_block(input logic [63:0] x, output logic [1343:0] b);
        for (int k = 0; k < 21; k++) b[k*64 +: 64] = kword(k, x);
    endtask

    task automatic load_ctrl(input logic [31:0] size, input logic [1:0] m);
        output_size = size; operation_mode = m; copy_control_regs_en = 1'b1;
        @(negedge clk);
        copy_control_regs_en = 1'b0;
    endtask

    task automatic send_block(input logic [1343:0] b);
        rate_input = b; output_buffer_we = 1'b1;
        @(negedge clk);
        output_buffer_we = 1'b0;
    endtask

    // Waits (bounded) for a valid word, accepts it, returns at the next negedge
    task automatic get_word(output logic [63:0] w, output logic l, output logic ok);
        int n = 0;
        ok = 1'b0; w = '0; l = 1'b0;
        dout_ready = 1'b1;
        while (!dout_valid && n < 50) begin @(negedge clk); n++; end
        if (dout_valid) begin
            w = dout; l = dout_last; ok = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
        tests++; if (output_buffer_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", output_buffer_ready); end
        tests++; if (dout !== 64'h0) begin fails++; $display("FAIL reset_dout: got %h expected 0", dout); end
        tests++; if (dout_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", dout_last); end
    endtask

    task automatic test_single_block;
        logic [1343:0] b; logic [63:0] w; logic l, ok;
        load_ctrl(32'd256, 2'b00);
        make_block(64'h0, b);
        send_block(b);
        tests++; if (dout_valid !== 1'b1 || output_buffer_ready !== 1'b0) begin
            fails++; $display("FAIL latency: got valid=%b ready=%b expected valid=1 ready=0", dout_valid, output_buffer_ready);
        end
        for (int k = 0; k < 4; k++) begin
            get_word(w, l, ok);
            tests++; if (!ok || w !== kword(k, 64'h0) || l !== (k == 3)) begin
                fails++; $display("FAIL single_word%0d: got %h last=%b ok=%b expected %h last=%b", k, w, l, ok, kword(k, 64'h0), k == 3);
            end
        end
        tests++; if (output_buffer_ready !== 1'b1 || dout_valid !== 1'b0) begin
            fails++; $display("FAIL single_ready_after: got ready=%b valid=%b expected 1 0", output_buffer_ready, dout_valid);
        end
    endtask

    task automatic test_two_blocks;
        logic [1343:0] b; logic [63:0] w, x; logic l, ok;
        int bad = 0; int lasts = 0;
        load_ctrl(32'd2688, 2'b00);
        for (int blk = 0; blk < 2; blk++) begin
            x = (blk == 0) ? 64'h0 : 64'hA5A5_0F0F_5A5A_F0F0;
            make_block(x, b);
            send_block(b);
            for (int k = 0; k < 21; k++) begin
                get_word(w, l, ok);
                if (!ok || w !== kword(k, x)) bad++;
                if (l) begin
                    lasts++;
                    if (blk != 1 || k != 20) bad++;
                end
            end
            tests++; if (output_buffer_ready !== 1'b1) begin
                fails++; $display("FAIL two_ready_blk%0d: got %b expected 1", blk, output_buffer_ready);
            end
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL two_words: got %0d bad words expected 0", bad); end
        tests++; if (lasts != 1) begin fails++; $display("FAIL two_last_count: got %0d expected 1", lasts); end
    endtask

    task automatic test_shake256_mask;
        logic [63:0] w; logic l, ok;
        int bad = 0;
        load_ctrl(32'd1120, 2'b01);
        send_block('1);
        for (int k = 0; k < 17; k++) begin
            get_word(w, l, ok);
            if (!ok || w !== 64'hFFFF_FFFF_FFFF_FFFF || l !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL s256_full_words: got %0d bad expected 0", bad); end
        tests++; if (output_buffer_ready !== 1'b1) begin fails++; $display("FAIL s256_ready: got %b expected 1", output_buffer_ready); end
        send_block('1);
        get_word(w, l, ok);
        tests++; if (!ok || w !== 64'h0000_0000_FFFF_FFFF || l !== 1'b1) begin
            fails++; $display("FAIL s256_masked: got %h last=%b expected 00000000ffffffff last=1", w, l);
        end
        repeat (2) @(negedge clk);
        tests++; if (dout_valid !== 1'b0 || output_buffer_ready !== 1'b1) begin
            fails++; $display("FAIL s256_done: got valid=%b ready=%b expected 0 1", dout_valid, output_buffer_ready);
        end
    endtask

    task automatic test_backpressure;
        logic [1343:0] b; logic [63:0] got_w [4]; logic [63:0] prev_w; logic prev_l, stall;
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int got = 0; int unstable = 0;
        load_ctrl(32'd256, 2'b00);
        make_block(64'h0123_4567_89AB_CDEF, b);
        send_block(b);
        stall = 1'b0; prev_w = '0; prev_l = 1'b0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            dout_ready = pat[c % 4];
            if (dout_valid) begin
                if (stall && (dout !== prev_w || dout_last !== prev_l)) unstable++;
                if (dout_ready) begin got_w[got] = dout; got++; stall = 1'b0; end
                else begin stall = 1'b1; prev_w = dout; prev_l = dout_last; end
            end
            @(negedge clk);
        end
        dout_ready = 1'b1;
        tests++; if (got != 4) begin fails++; $display("FAIL bp_count: got %0d expected 4", got); end
        tests++; if (unstable != 0) begin fails++; $display("FAIL bp_hold: got %0d changes expected 0", unstable); end
        for (int k = 0; k < 4 && k < got; k++) begin
            tests++; if (got_w[k] !== kword(k, 64'h0123_4567_89AB_CDEF)) begin
                fails++; $display("FAIL bp_word%0d: got %h expected %h", k, got_w[k], kword(k, 64'h0123_4567_89AB_CDEF));
            end
        end
        repeat (2) @(negedge clk);
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL bp_extra: got valid=%b expected 0", dout_valid); end
    endtask

    task automatic test_copy_during_drain;
        logic [1343:0] b; logic [63:0] w; logic l, ok;
        int bad = 0;
        load_ctrl(32'd512, 2'b00);
        make_block(64'h0, b);
        send_block(b);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                output_size = 32'd64; operation_mode = 2'b01; copy_control_regs_en = 1'b1;
            end
            get_word(w, l, ok);
            copy_control_regs_en = 1'b0;
            if (!ok || w !== kword(k, 64'h0) || l !== (k == 7)) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL copy_drain_words: got %0d bad expected 0", bad); end
        send_block('1);
        get_word(w, l, ok);
        tests++; if (!ok || w !== 64'hFFFF_FFFF_FFFF_FFFF || l !== 1'b1) begin
            fails++; $display("FAIL copy_next_block: got %h last=%b expected ffffffffffffffff last=1", w, l);
        end
        repeat (2) @(negedge clk);
        tests++; if (dout_valid !== 1'b0 || output_buffer_ready !== 1'b1) begin
            fails++; $display("FAIL copy_done: got valid=%b ready=%b expected 0 1", dout_valid, output_buffer_ready);
        end
    endtask

    task automatic test_zero_and_reset;
        logic [1343:0] b; logic [63:0] w; logic l, ok;
        int seen = 0;
        load_ctrl(32'd0, 2'b00);
        make_block(64'h0, b);
        send_block(b);
        repeat (3) begin
            if (dout_valid !== 1'b0 || output_buffer_ready !== 1'b1) seen++;
            @(negedge clk);
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL zero_size: got %0d bad cycles expected 0", seen); end
        // copy and block in the same EMPTY cycle: new length decides acceptance
        make_block(64'hFFFF_0000_FFFF_0000, b);
        output_size = 32'd128; operation_mode = 2'b00; copy_control_regs_en = 1'b1;
        send_block(b);
        copy_control_regs_en = 1'b0;
        get_word(w, l, ok);
        tests++; if (!ok || w !== kword(0, 64'hFFFF_0000_FFFF_0000) || l !== 1'b0) begin
            fails++; $display("FAIL copy_we_w0: got %h last=%b expected %h last=0", w, l, kword(0, 64'hFFFF_0000_FFFF_0000));
        end
        get_word(w, l, ok);
        tests++; if (!ok || w !== kword(1, 64'hFFFF_0000_FFFF_0000) || l !== 1'b1) begin
            fails++; $display("FAIL copy_we_w1: got %h last=%b expected %h last=1", w, l, kword(1, 64'hFFFF_0000_FFFF_0000));
        end
        // reset in the middle of a drain
        load_ctrl(32'd2688, 2'b00);
        send_block(b);
        get_word(w, l, ok);
        get_word(w, l, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (dout_valid !== 1'b0 || output_buffer_ready !== 1'b1 || dout_last !== 1'b0 || dout !== 64'h0) begin
            fails++; $display("FAIL mid_reset: got valid=%b ready=%b last=%b dout=%h expected 0 1 0 0", dout_valid, output_buffer_ready, dout_last, dout);
        end
        seen = 0;
        repeat (4) begin
            if (dout_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL post_reset_quiet: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_protocol;
        tests++; if (violations != 0) begin fails++; $display("FAIL protocol: got %0d busy-strobes expected 0", violations); end
    endtask

    initial begin
        rst = 1'b1; rate_input = '0; output_buffer_we = 1'b0; output_size = '0;
        operation_mode = '0; copy_control_regs_en = 1'b0; dout_ready = 1'b1;
        @(negedge clk);
        test_reset;
        test_single_block;
        test_two_blocks;
        test_shake256_mask;
        test_backpressure;
        test_copy_during_drain;
        test_zero_and_reset;
        test_protocol;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
